// File: rtl/neur_packer.sv
// Packs signed 8-bit elements into 32-bit words in 8-, 4- or 2-bit lanes.
// The lane layout matches the neural-lane decoder. Narrow lanes saturate to their range.
module neur_packer #(
  parameter int SAT_CNT_W = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [2:0]           mode_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [7:0]           in_data_i,
  input  logic                 flush_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [31:0]          out_data_o,
  output logic                 out_partial_o,
  output logic                 sat_o,
  output logic [SAT_CNT_W-1:0] sat_cnt_o
);
  localparam logic [1:0] MODE_4B = 2'b10;
  localparam logic [1:0] MODE_2B = 2'b11;

  logic [31:0]          fill_q, fill_d, word_d;
  logic [3:0]           idx_q, idx_d;
  logic [1:0]           mode_q, mode_d;
  logic                 out_valid_q, out_partial_q, sat_q;
  logic [31:0]          out_data_q;
  logic [SAT_CNT_W-1:0] sat_cnt_q;

  logic                 accept, last_slot, flush_take, load, clipped;
  logic [1:0]           eff_mode;
  logic [3:0]           last_idx;
  logic signed [7:0]    din, clip_val;
  logic [7:0]           lane_mask;
  logic [4:0]           lsb;
  logic [31:0]          lane_bits;
  logic                 unused_mode;

  // Bit 2 of the mode selects signedness; every element is signed here.
  assign unused_mode = mode_i[2];

  assign in_ready_o = ~out_valid_q | out_ready_i;
  assign accept     = in_valid_i & in_ready_o;
  assign eff_mode   = (idx_q == 4'd0) ? mode_i[1:0] : mode_q;
  assign din        = in_data_i;

  // Clamp, lane size and bit position of the current slot.
  always_comb begin
    clip_val  = din;
    last_idx  = 4'd3;
    lane_mask = 8'hFF;
    lsb       = 5'd24 - {idx_q[1:0], 3'b000};
    case (eff_mode)
      MODE_4B: begin
        last_idx  = 4'd7;
        lane_mask = 8'h0F;
        if (din > 8'sd7)       clip_val = 8'sd7;
        else if (din < -8'sd8) clip_val = -8'sd8;
        // Even slots fill the upper half-word, odd slots the lower one.
        lsb = idx_q[0] ? (5'd12 - {1'b0, idx_q[2:1], 2'b00})
                       : (5'd28 - {1'b0, idx_q[2:1], 2'b00});
      end
      MODE_2B: begin
        last_idx  = 4'd15;
        lane_mask = 8'h03;
        if (din > 8'sd1)       clip_val = 8'sd1;
        else if (din < -8'sd2) clip_val = -8'sd2;
        lsb = 5'd30 - {idx_q, 1'b0};
      end
      default: ;
    endcase
    clipped   = (clip_val != din);
    lane_bits = {24'd0, clip_val & lane_mask} << lsb;
  end

  assign last_slot = accept & (idx_q == last_idx);

  always_comb begin
    fill_d = fill_q;
    idx_d  = idx_q;
    mode_d = mode_q;
    if (accept) begin
      fill_d = fill_q | lane_bits;
      idx_d  = last_slot ? 4'd0 : idx_q + 4'd1;
      if (idx_q == 4'd0) mode_d = mode_i[1:0];
    end
    word_d     = fill_d;
    flush_take = flush_i & in_ready_o & (idx_d != 4'd0);
    load       = last_slot | flush_take;
    if (load) begin
      fill_d = 32'd0;
      idx_d  = 4'd0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      fill_q        <= 32'd0;
      idx_q         <= 4'd0;
      mode_q        <= 2'b00;
      out_valid_q   <= 1'b0;
      out_data_q    <= 32'd0;
      out_partial_q <= 1'b0;
      sat_q         <= 1'b0;
      sat_cnt_q     <= '0;
    end else begin
      fill_q <= fill_d;
      idx_q  <= idx_d;
      mode_q <= mode_d;
      if (load) begin
        out_valid_q   <= 1'b1;
        out_data_q    <= word_d;
        out_partial_q <= ~last_slot;
      end else if (out_ready_i) begin
        out_valid_q   <= 1'b0;
        out_data_q    <= 32'd0;
        out_partial_q <= 1'b0;
      end
      sat_q <= accept & clipped;
      if (accept & clipped & ~&sat_cnt_q)
        sat_cnt_q <= sat_cnt_q + {{(SAT_CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign out_valid_o   = out_valid_q;
  assign out_data_o    = out_data_q;
  assign out_partial_o = out_partial_q;
  assign sat_o         = sat_q;
  assign sat_cnt_o     = sat_cnt_q;

endmodule

// File: tb/tb_neur_packer.sv
// Directed and random checks of neur_packer against a word-level reference model.
module tb_neur_packer;
  localparam int SCW     = 4;
  localparam int CNT_MAX = (1 << SCW) - 1;

  logic           clk = 1'b0;
  logic           rst_n, in_valid, flush, out_ready;
  logic [2:0]     mode;
  logic [7:0]     in_data;
  logic           in_ready_o, out_valid_o, out_partial_o, sat_o;
  logic [31:0]    out_data_o;
  logic [SCW-1:0] sat_cnt_o;

  int ntests = 0;
  int nfail  = 0;

  // Reference model state: elements of the word being built, plus the output slot.
  int          m_elems[$];
  logic [1:0]  m_mode;
  logic        m_ov, m_op, m_sat;
  logic [31:0] m_ow;
  int          m_cnt;
  logic        last_acc;

  neur_packer #(.SAT_CNT_W(SCW)) dut (
    .clk_i(clk), .rst_ni(rst_n), .mode_i(mode), .in_valid_i(in_valid),
    .in_ready_o(in_ready_o), .in_data_i(in_data), .flush_i(flush),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready), .out_data_o(out_data_o),
    .out_partial_o(out_partial_o), .sat_o(sat_o), .sat_cnt_o(sat_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int lane_bits(input logic [1:0] md);
    return (md == 2'b10) ? 4 : (md == 2'b11) ? 2 : 8;
  endfunction

  function automatic int clamp(input int v, input logic [1:0] md);
    int lo, hi;
    if (md == 2'b10) begin lo = -8; hi = 7; end
    else if (md == 2'b11) begin lo = -2; hi = 1; end
    else return v;
    return (v > hi) ? hi : (v < lo) ? lo : v;
  endfunction

  function automatic logic [31:0] pack_word();
    logic [31:0] w;
    int bits, lsb;
    w    = 32'd0;
    bits = lane_bits(m_mode);
    for (int k = 0; k < m_elems.size(); k++) begin
      if (bits == 8)      lsb = 24 - 8 * k;
      else if (bits == 2) lsb = 30 - 2 * k;
      else                lsb = (k % 2 == 0) ? 28 - 4 * (k / 2) : 12 - 4 * (k / 2);
      w |= (32'(m_elems[k]) & ((32'd1 << bits) - 32'd1)) << lsb;
    end
    return w;
  endfunction

  // One clock: predict the edge with the model, then compare all outputs.
  task automatic tick();
    logic rdy, done, fl;
    int v, c;
    #1;
    rdy = !m_ov || out_ready;
    if (rst_n) chk("in_ready", 32'(in_ready_o), 32'(rdy));
    last_acc = in_valid && rdy && rst_n;
    m_sat = 1'b0;
    done  = 1'b0;
    if (!rst_n) begin
      m_elems.delete();
      m_mode = 2'b00; m_ov = 1'b0; m_op = 1'b0; m_ow = 32'd0; m_cnt = 0;
    end else begin
      if (last_acc) begin
        if (m_elems.size() == 0) m_mode = mode[1:0];
        v = int'($signed(in_data));
        c = clamp(v, m_mode);
        if (c != v) begin
          m_sat = 1'b1;
          if (m_cnt < CNT_MAX) m_cnt++;
        end
        m_elems.push_back(c);
        done = (m_elems.size() == 32 / lane_bits(m_mode));
      end
      fl = flush && rdy && (m_elems.size() > 0) && !done;
      if (m_ov && out_ready) begin m_ov = 1'b0; m_ow = 32'd0; m_op = 1'b0; end
      if (done || fl) begin
        m_ow = pack_word(); m_ov = 1'b1; m_op = fl;
        m_elems.delete();
      end
    end
    @(posedge clk);
    #1;
    chk("out_valid", 32'(out_valid_o), 32'(m_ov));
    chk("out_data", out_data_o, m_ow);
    chk("out_partial", 32'(out_partial_o), 32'(m_op));
    chk("sat", 32'(sat_o), 32'(m_sat));
    chk("sat_cnt", 32'(sat_cnt_o), 32'(m_cnt));
    $display("[TB] t=%0t acc=%0b d=%h flush=%0b ordy=%0b -> ov=%0b data=%h part=%0b sat=%0b cnt=%0d",
             $time, last_acc, in_data, flush, out_ready, out_valid_o, out_data_o,
             out_partial_o, sat_o, sat_cnt_o);
  endtask

  task automatic send(input logic [7:0] d);
    in_valid = 1'b1;
    in_data  = d;
    for (int t = 0; t < 20; t++) begin
      tick();
      if (last_acc) break;
    end
    ntests++;
    assert (last_acc) else begin
      nfail++;
      $error("FAIL send_timeout observed=%0b expected=1", last_acc);
    end
    in_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = 8'd0; flush = 1'b0;
    mode = 3'b000; out_ready = 1'b1;
    m_mode = 2'b00; m_ov = 1'b0; m_op = 1'b0; m_ow = 32'd0; m_cnt = 0; m_sat = 1'b0;
    @(posedge clk);
    tick(); tick();
    rst_n = 1'b1;

    // 8-bit packing
    mode = 3'b000;
    send(8'h11); send(8'h22); send(8'h33); send(8'h44);
    chk("w8_data", out_data_o, 32'h11223344);
    chk("w8_partial", 32'(out_partial_o), 32'd0);

    // 4-bit lane interleave
    mode = 3'b010;
    send(8'd1); send(8'd2); send(8'd3); send(8'd4);
    send(8'd5); send(8'd6); send(8'd7); send(8'hFF);
    chk("w4_data", out_data_o, 32'h1357246F);

    // Saturation in 4-bit, then all +1 in 2-bit
    send(8'd100); send(8'h9C);
    for (int i = 0; i < 6; i++) send(8'd0);
    chk("w4sat_data", out_data_o, 32'h70008000);
    chk("w4sat_cnt", 32'(sat_cnt_o), 32'd2);
    mode = 3'b011;
    for (int i = 0; i < 16; i++) send(8'd1);
    chk("w2_data", out_data_o, 32'h55555555);

    // Flush of a partial word; mode change mid-word is ignored
    mode = 3'b000;
    send(8'h01);
    mode = 3'b010;
    send(8'h02); send(8'h03);
    flush = 1'b1;
    tick();
    chk("flush_data", out_data_o, 32'h01020300);
    chk("flush_partial", 32'(out_partial_o), 32'd1);
    tick();
    chk("flush_idle_valid", 32'(out_valid_o), 32'd0);
    flush = 1'b0;

    // Backpressure: input stalls while a word is held
    mode = 3'b000;
    out_ready = 1'b0;
    send(8'h01); send(8'h02); send(8'h03); send(8'h04);
    in_valid = 1'b1; in_data = 8'h05;
    tick(); tick(); tick();
    chk("bp_hold_data", out_data_o, 32'h01020304);
    chk("bp_ready_low", 32'(in_ready_o), 32'd0);
    out_ready = 1'b1;
    send(8'h05); send(8'h06); send(8'h07); send(8'h08);
    chk("bp_second_word", out_data_o, 32'h05060708);

    // Reset in the middle of a word
    send(8'h77); send(8'h66);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    send(8'hAA); send(8'hBB); send(8'hCC); send(8'hDD);
    chk("rst_word", out_data_o, 32'hAABBCCDD);
    chk("rst_cnt", 32'(sat_cnt_o), 32'd0);

    // Random traffic; the narrow counter also hits its saturation point
    for (int i = 0; i < 1500; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = 8'($urandom);
      flush     = ($urandom_range(0, 11) == 0);
      mode      = 3'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      rst_n     = ($urandom_range(0, 499) != 0);
      tick();
    end
    rst_n = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    tick();

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
